// File: rtl/micro_mult_seq.sv
// Sequential shift-add multiplier with optional accumulate; one result per WIDTH+1 cycles.
// Define MICRO_MULT_SIGNED_EN for two's-complement operands (sign-magnitude internally).
module micro_mult_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 accumulate,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   partial_q, partial_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            acc_q, acc_d;
    logic [PW-1:0]   result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [WIDTH-1:0] a_mag_c, b_mag_c;
    logic [PW-1:0]    sum_c, prod_c;

`ifdef MICRO_MULT_SIGNED_EN
    logic sign_q, sign_d;

    // Magnitudes fit unsigned in WIDTH bits, including the most-negative value.
    always_comb begin
        a_mag_c = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
        b_mag_c = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    end

    assign sum_c  = partial_q + (mplier_q[0] ? mcand_q : '0);
    assign prod_c = sign_q ? (~sum_c + PW'(1)) : sum_c;
`else
    always_comb begin
        a_mag_c = a;
        b_mag_c = b;
    end

    assign sum_c  = partial_q + (mplier_q[0] ? mcand_q : '0);
    assign prod_c = sum_c;
`endif

    // Next-state and datapath.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        partial_d = partial_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        result_d  = result_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
`ifdef MICRO_MULT_SIGNED_EN
        sign_d    = sign_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mcand_d   = PW'(a_mag_c);
                    mplier_d  = b_mag_c;
                    acc_d     = accumulate;
                    partial_d = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = S_RUN;
`ifdef MICRO_MULT_SIGNED_EN
                    sign_d    = a[WIDTH-1] ^ b[WIDTH-1];
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                partial_d = sum_c;
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Final iteration's add is folded into the commit value.
                    result_d = acc_q ? (result_q + prod_c) : prod_c;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            partial_q <= '0;
            cnt_q     <= '0;
            acc_q     <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MICRO_MULT_SIGNED_EN
            sign_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            partial_q <= partial_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MICRO_MULT_SIGNED_EN
            sign_q    <= sign_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_micro_mult_seq.sv
// Randomized self-checking bench for micro_mult_seq at WIDTH=4 and WIDTH=8.
module tb_micro_mult_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start4, acc4, busy4, done4;
    logic [3:0] a4, b4;
    logic [7:0] res4;

    logic        start8, acc8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;

    int errors = 0;
    int checks = 0;
    logic [7:0]  model4 = '0;
    logic [15:0] model8 = '0;

    micro_mult_seq #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .accumulate(acc4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .result(res4)
    );

    micro_mult_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .accumulate(acc8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .result(res8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer multiply (signed when enabled), optional add, modulo 2^(2w).
    function automatic logic [15:0] ref_mul(input int w, input logic [15:0] a, input logic [15:0] b,
                                            input bit acc, input logic [15:0] prev);
        longint x, y, p, mask;
        x = longint'(a);
        y = longint'(b);
`ifdef MICRO_MULT_SIGNED_EN
        if (a[w-1]) x = x - (longint'(1) << w);
        if (b[w-1]) y = y - (longint'(1) << w);
`endif
        mask = (longint'(1) << (2 * w)) - 1;
        p = x * y + (acc ? longint'(prev) : 0);
        return 16'(p & mask);
    endfunction

    // Starts at a negedge; returns at the negedge of the done cycle. poke re-asserts start mid-run.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit acc, input bit poke);
        logic [7:0] exp;
        exp    = 8'(ref_mul(4, 16'(a), 16'(b), acc, 16'(model4)));
        start4 = 1'b1; a4 = a; b4 = b; acc4 = acc;
        @(negedge clk);
        check("busy4_first", 32'(busy4), 32'd1);
        check("done4_first", 32'(done4), 32'd0);
        start4 = poke;
        if (poke) a4 = 4'd0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            start4 = 1'b0;
            check("busy4_run", 32'(busy4), 32'd1);
            check("done4_run", 32'(done4), 32'd0);
            check("res4_hold", 32'(res4), 32'(model4));
        end
        @(negedge clk);
        model4 = exp;
        check("done4_pulse", 32'(done4), 32'd1);
        check("busy4_done", 32'(busy4), 32'd0);
        check("res4_commit", 32'(res4), 32'(model4));
    endtask

    task automatic idle4();
        @(negedge clk);
        check("done4_idle", 32'(done4), 32'd0);
        check("busy4_idle", 32'(busy4), 32'd0);
        check("res4_idle", 32'(res4), 32'(model4));
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit acc);
        logic [15:0] exp;
        exp    = ref_mul(8, 16'(a), 16'(b), acc, model8);
        start8 = 1'b1; a8 = a; b8 = b; acc8 = acc;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            check("busy8_run", 32'(busy8), 32'd1);
            check("done8_run", 32'(done8), 32'd0);
        end
        @(negedge clk);
        model8 = exp;
        check("done8_pulse", 32'(done8), 32'd1);
        check("busy8_done", 32'(busy8), 32'd0);
        check("res8_commit", 32'(res8), 32'(model8));
        @(negedge clk);
        check("done8_idle", 32'(done8), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start4 = 1'b0; acc4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; acc8 = 1'b0; a8 = '0; b8 = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check("rst_res4", 32'(res4), 32'd0);
        check("rst_res8", 32'(res8), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Overwrite then back-to-back accumulate from the DONE cycle.
        op4(4'd15, 4'd15, 1'b0, 1'b0);
`ifndef MICRO_MULT_SIGNED_EN
        check("const_15x15", 32'(res4), 32'hE1);
`endif
        op4(4'd15, 4'd15, 1'b1, 1'b0);
`ifndef MICRO_MULT_SIGNED_EN
        check("const_acc", 32'(res4), 32'hC2);
`endif
        idle4();

        // start during RUN must be ignored; exactly one done pulse.
        op4(4'd7, 4'd3, 1'b0, 1'b1);
`ifndef MICRO_MULT_SIGNED_EN
        check("const_7x3", 32'(res4), 32'd21);
`endif
        idle4();
        idle4();

        // Asynchronous reset mid-run discards the operation.
        start4 = 1'b1; a4 = 4'd9; b4 = 4'd9; acc4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model4 = '0;
        check("arst_busy4", 32'(busy4), 32'd0);
        check("arst_done4", 32'(done4), 32'd0);
        check("arst_res4", 32'(res4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) idle4();
        op4(4'd2, 4'd3, 1'b0, 1'b0);
        check("const_2x3", 32'(res4), 32'd6);
        idle4();

`ifdef MICRO_MULT_SIGNED_EN
        op4(4'hD, 4'd5, 1'b0, 1'b0);
        check("const_m3x5", 32'(res4), 32'hF1);
        op4(4'h8, 4'h8, 1'b0, 1'b0);
        check("const_m8xm8", 32'(res4), 32'h40);
        idle4();
`endif

        // Random mix of overwrite/accumulate, back-to-back and idle gaps.
        for (int n = 0; n < 40; n++) begin
            op4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle4();
        end
        idle4();

        op8(8'd255, 8'd255, 1'b0);
`ifndef MICRO_MULT_SIGNED_EN
        check("const_255x255", 32'(res8), 32'hFE01);
`endif
        op8(8'd0, 8'd200, 1'b0);
        check("const_0x200", 32'(res8), 32'd0);
        for (int n = 0; n < 8; n++) op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Both-high check runs each cycle on the low phase.
    always @(negedge clk) begin
        if (!rst && ((busy4 && done4) || (busy8 && done8))) begin
            check("busy_done_excl", 32'd1, 32'd0);
        end
    end

endmodule
